halut_encoder_scheduler: RTL and testbench



---
 rtl/halut_encoder_scheduler_if.sv | 22 ++
 rtl/halut_encoder_scheduler.sv | 188 ++++++++++++++++++
 tb/tb_halut_encoder_scheduler.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/halut_encoder_scheduler_if.sv
// Threshold-write bus and input-row handshake between the layer controller and
// the HALUT encoder scheduler.
interface halut_encoder_scheduler_if #(
  parameter int unsigned GAddrWidth    = 9,
  parameter int unsigned DataTypeWidth = 16
);
  logic [GAddrWidth-1:0]    cfg_waddr_i;
  logic [DataTypeWidth-1:0] cfg_wdata_i;
  logic                     cfg_we_i;
  logic                     row_valid_i;
  logic                     row_ready_o;

  modport master (
    output cfg_waddr_i, cfg_wdata_i, cfg_we_i, row_valid_i,
    input  row_ready_o
  );

  modport slave (
    input  cfg_waddr_i, cfg_wdata_i, cfg_we_i, row_valid_i,
    output row_ready_o
  );
endinterface

// File: rtl/halut_encoder_scheduler.sv
// Sequences the HALUT encoder bank: routes threshold writes in IDLE and drives the shared
// encoder enable per input row. Optional stall counter under HALUT_ENC_SCHED_PERF_CNT_EN.
module halut_encoder_scheduler #(
  parameter int unsigned K             = 16,
  parameter int unsigned C             = 32,
  parameter int unsigned DataTypeWidth = 16,
  parameter int unsigned EncUnits      = 4,
  parameter int unsigned RowCntWidth   = 16,
  localparam int unsigned TreeDepth          = $clog2(K),
  localparam int unsigned CPerEncUnit        = C / EncUnits,
  localparam int unsigned ThreshMemAddrWidth = $clog2(CPerEncUnit * K),
  localparam int unsigned GAddrWidth         = $clog2(C * K),
  localparam int unsigned GrpWidth           = $clog2(CPerEncUnit),
  localparam int unsigned LvlWidth           = $clog2(TreeDepth)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  halut_encoder_scheduler_if.slave      bus,
  output logic [ThreshMemAddrWidth-1:0] enc_waddr_o,
  output logic [DataTypeWidth-1:0]      enc_wdata_o,
  output logic [EncUnits-1:0]           enc_we_o,
  input  logic                          start_i,
  input  logic [RowCntWidth-1:0]        num_rows_i,
  output logic                          encoder_o,
  output logic [GrpWidth-1:0]           grp_o,
  output logic [LvlWidth-1:0]           level_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          cfg_err_o
`ifdef HALUT_ENC_SCHED_PERF_CNT_EN
  ,
  output logic [31:0]                   stall_cnt_o
`endif
);
  localparam int unsigned CbWidth = GAddrWidth - TreeDepth;

  typedef enum logic [1:0] {IDLE, WAIT_ROW, ENCODE, DRAIN} state_e;

  state_e                        state_q, state_d;
  logic [RowCntWidth-1:0]        num_rows_q, num_rows_d;
  logic [RowCntWidth-1:0]        rows_done_q, rows_done_d;
  logic [LvlWidth-1:0]           lvl_q, lvl_d;
  logic [GrpWidth-1:0]           grp_q, grp_d;
  logic                          done_q, done_d;
  logic                          err_q, err_d;
  logic [EncUnits-1:0]           we_q, we_d;
  logic [ThreshMemAddrWidth-1:0] waddr_q, waddr_d;
  logic [DataTypeWidth-1:0]      wdata_q, wdata_d;
`ifdef HALUT_ENC_SCHED_PERF_CNT_EN
  logic [31:0]                   stall_q, stall_d;
`endif

  logic [CbWidth-1:0]   cb;
  logic [TreeDepth-1:0] kidx;
  logic                 last_cyc, last_row, row_ready, encoder;

  // Codebook c selects encoder c mod EncUnits; its local row is c / EncUnits.
  assign cb       = bus.cfg_waddr_i[GAddrWidth-1:TreeDepth];
  assign kidx     = bus.cfg_waddr_i[TreeDepth-1:0];
  assign last_cyc = (lvl_q == LvlWidth'(TreeDepth - 1)) && (grp_q == GrpWidth'(CPerEncUnit - 1));
  assign last_row = (rows_done_q + RowCntWidth'(1)) == num_rows_q;

  always_comb begin
    state_d     = state_q;
    num_rows_d  = num_rows_q;
    rows_done_d = rows_done_q;
    lvl_d       = lvl_q;
    grp_d       = grp_q;
    done_d      = 1'b0;
    err_d       = err_q;
    we_d        = '0;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    row_ready   = 1'b0;
    encoder     = 1'b0;
`ifdef HALUT_ENC_SCHED_PERF_CNT_EN
    stall_d     = stall_q;
`endif

    if (bus.cfg_we_i) begin
      if (state_q == IDLE) begin
        we_d    = EncUnits'(1) << (cb % CbWidth'(EncUnits));
        waddr_d = {GrpWidth'(cb / CbWidth'(EncUnits)), kidx};
        wdata_d = bus.cfg_wdata_i;
      end else begin
        err_d = 1'b1;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          num_rows_d  = num_rows_i;
          rows_done_d = '0;
          err_d       = 1'b0;
`ifdef HALUT_ENC_SCHED_PERF_CNT_EN
          stall_d     = '0;
`endif
          state_d     = (num_rows_i == '0) ? DRAIN : WAIT_ROW;
        end
      end
      WAIT_ROW: begin
        row_ready = 1'b1;
        if (bus.row_valid_i) begin
          state_d = ENCODE;
          lvl_d   = '0;
          grp_d   = '0;
        end
`ifdef HALUT_ENC_SCHED_PERF_CNT_EN
        else if (stall_q != '1) begin
          stall_d = stall_q + 32'd1;
        end
`endif
      end
      ENCODE: begin
        encoder = 1'b1;
        if (last_cyc) begin
          lvl_d       = '0;
          grp_d       = '0;
          rows_done_d = rows_done_q + RowCntWidth'(1);
          if (last_row) begin
            state_d = DRAIN;
          end else begin
            // Accepting the next row here keeps the encoders busy without a bubble.
            row_ready = 1'b1;
            if (!bus.row_valid_i) state_d = WAIT_ROW;
          end
        end else if (lvl_q == LvlWidth'(TreeDepth - 1)) begin
          lvl_d = '0;
          grp_d = grp_q + GrpWidth'(1);
        end else begin
          lvl_d = lvl_q + LvlWidth'(1);
        end
      end
      DRAIN: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      num_rows_q  <= '0;
      rows_done_q <= '0;
      lvl_q       <= '0;
      grp_q       <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      we_q        <= '0;
      waddr_q     <= '0;
      wdata_q     <= '0;
`ifdef HALUT_ENC_SCHED_PERF_CNT_EN
      stall_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      num_rows_q  <= num_rows_d;
      rows_done_q <= rows_done_d;
      lvl_q       <= lvl_d;
      grp_q       <= grp_d;
      done_q      <= done_d;
      err_q       <= err_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
`ifdef HALUT_ENC_SCHED_PERF_CNT_EN
      stall_q     <= stall_d;
`endif
    end
  end

  assign bus.row_ready_o = row_ready;
  assign encoder_o       = encoder;
  assign level_o         = lvl_q;
  assign grp_o           = grp_q;
  assign busy_o          = (state_q != IDLE);
  assign done_o          = done_q;
  assign cfg_err_o       = err_q;
  assign enc_we_o        = we_q;
  assign enc_waddr_o     = waddr_q;
  assign enc_wdata_o     = wdata_q;
`ifdef HALUT_ENC_SCHED_PERF_CNT_EN
  assign stall_cnt_o     = stall_q;
`endif
endmodule

// File: tb/tb_halut_encoder_scheduler.sv
// Randomized self-checking bench for halut_encoder_scheduler (K=16, C=32, EncUnits=4),
// checked against a cycle-timeline model derived from the row/handshake rules.
module tb_halut_encoder_scheduler;
  localparam int K   = 16;
  localparam int C   = 32;
  localparam int EU  = 4;
  localparam int TD  = 4;
  localparam int CPE = C / EU;
  localparam int ENC = CPE * TD;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] num_rows;
  logic [6:0]  enc_waddr;
  logic [15:0] enc_wdata;
  logic [3:0]  enc_we;
  logic        encoder;
  logic [2:0]  grp;
  logic [1:0]  level;
  logic        busy, done, cfg_err;
`ifdef HALUT_ENC_SCHED_PERF_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int gap_q[8];
  bit err_sticky = 1'b0;

  halut_encoder_scheduler_if #(.GAddrWidth(9), .DataTypeWidth(16)) bus_if ();

  halut_encoder_scheduler dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .bus         (bus_if),
    .enc_waddr_o (enc_waddr),
    .enc_wdata_o (enc_wdata),
    .enc_we_o    (enc_we),
    .start_i     (start),
    .num_rows_i  (num_rows),
    .encoder_o   (encoder),
    .grp_o       (grp),
    .level_o     (level),
    .busy_o      (busy),
    .done_o      (done),
    .cfg_err_o   (cfg_err)
`ifdef HALUT_ENC_SCHED_PERF_CNT_EN
    ,
    .stall_cnt_o (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; num_rows = '0;
    bus_if.cfg_waddr_i = '0; bus_if.cfg_wdata_i = '0; bus_if.cfg_we_i = 1'b0;
    bus_if.row_valid_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (enc_we !== 4'b0) begin errors++; $display("FAIL reset enc_we_o got %b want 0", enc_we); end
    checks++; if (enc_waddr !== 7'h0 || enc_wdata !== 16'h0) begin errors++; $display("FAIL reset enc_waddr/wdata got %h/%h want 0/0", enc_waddr, enc_wdata); end
    checks++; if ({encoder, busy, done, cfg_err, bus_if.row_ready_o} !== 5'b0) begin errors++; $display("FAIL reset ctrl {enc,busy,done,err,rdy} got %b want 00000", {encoder, busy, done, cfg_err, bus_if.row_ready_o}); end
    checks++; if (grp !== 3'd0 || level !== 2'd0) begin errors++; $display("FAIL reset grp/level got %0d/%0d want 0/0", grp, level); end
`ifdef HALUT_ENC_SCHED_PERF_CNT_EN
    checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL reset stall_cnt_o got %0d want 0", stall_cnt); end
`endif
  endtask

  task automatic test_cfg_routing();
    bit seen [EU][CPE*K];
    int cnt [EU];
    int pa, c, kk, unit, loc;
    logic [15:0] pd;
    @(posedge clk); #1;
    bus_if.cfg_waddr_i = 9'h1A3; bus_if.cfg_wdata_i = 16'h3C00; bus_if.cfg_we_i = 1'b1;
    @(posedge clk); #1;
    bus_if.cfg_we_i = 1'b0;
    @(negedge clk);
    checks++; if (enc_we !== 4'b0100) begin errors++; $display("FAIL cfg_fixed enc_we_o got %b want 0100", enc_we); end
    checks++; if (enc_waddr !== 7'h63) begin errors++; $display("FAIL cfg_fixed enc_waddr_o got %h want 63", enc_waddr); end
    checks++; if (enc_wdata !== 16'h3C00) begin errors++; $display("FAIL cfg_fixed enc_wdata_o got %h want 3c00", enc_wdata); end
    @(negedge clk);
    checks++; if (enc_we !== 4'b0) begin errors++; $display("FAIL cfg_pulse enc_we_o got %b want 0", enc_we); end

    for (int u = 0; u < EU; u++) begin
      cnt[u] = 0;
      for (int j = 0; j < CPE*K; j++) seen[u][j] = 1'b0;
    end
    pa = 0; pd = '0;
    for (int a = 0; a <= C*K; a++) begin
      @(posedge clk); #1;
      if (a < C*K) begin
        bus_if.cfg_waddr_i = 9'(a);
        bus_if.cfg_wdata_i = 16'($urandom);
        bus_if.cfg_we_i    = 1'b1;
      end else begin
        bus_if.cfg_we_i = 1'b0;
      end
      @(negedge clk);
      if (a > 0) begin
        c = pa / K; kk = pa % K; unit = c % EU; loc = (c / EU) * K + kk;
        checks++; if (enc_we !== 4'(1 << unit) || enc_waddr !== 7'(loc) || enc_wdata !== pd) begin
          errors++;
          $display("FAIL cfg_sweep addr=%0d got we=%b la=%0d d=%h want we=%b la=%0d d=%h", pa, enc_we, enc_waddr, enc_wdata, 4'(1 << unit), loc, pd);
        end
        if (enc_we == 4'(1 << unit) && !seen[unit][enc_waddr]) begin
          seen[unit][enc_waddr] = 1'b1;
          cnt[unit]++;
        end
      end
      pa = a; pd = bus_if.cfg_wdata_i;
    end
    for (int u = 0; u < EU; u++) begin
      checks++; if (cnt[u] != CPE*K) begin errors++; $display("FAIL cfg_distinct unit %0d got %0d local addresses want %0d", u, cnt[u], CPE*K); end
    end
    @(negedge clk);
    checks++; if (enc_we !== 4'b0) begin errors++; $display("FAIL cfg_idle enc_we_o got %b want 0", enc_we); end
  endtask

  // Timeline model: cycle 0 carries start; row i is handshaken at h[i] and encoded
  // during h[i]+1 .. h[i]+ENC. wr_cyc: -1 none, 0 with start, >0 that cycle, -2 random busy cycle.
  task automatic run_rows(input string name, input int n, input int wr_cyc_in);
    int h[8];
    int last_end, tend, r, vstart, exp_stall, wr_cyc, lo, lend;
    bit e_enc[1024], e_busy[1024], e_done[1024], e_rdy[1024], e_err[1024];
    logic [3:0] e_we[1024];
    logic [1:0] e_lvl[1024];
    logic [2:0] e_grp[1024];
    logic [8:0] wa;
    logic [15:0] wd;
    int e_wa;

    exp_stall = 0;
    for (int i = 0; i < n; i++) begin
      if (i == 0) begin
        h[0] = 1 + gap_q[0];
        exp_stall = gap_q[0];
      end else begin
        lend = h[i-1] + ENC;
        if (h[i-1] + gap_q[i] + 1 <= lend) h[i] = lend;
        else begin
          h[i] = h[i-1] + gap_q[i] + 1;
          exp_stall += gap_q[i] - ENC;
        end
      end
    end
    last_end = (n == 0) ? 0 : h[n-1] + ENC;
    tend = last_end + 4;
    wr_cyc = (wr_cyc_in == -2) ? int'($urandom_range(1, last_end + 1)) : wr_cyc_in;
    wa = 9'($urandom_range(0, C*K - 1));
    wd = 16'($urandom);
    e_wa = ((int'(wa) / K) / EU) * K + int'(wa) % K;

    for (int t = 0; t <= tend; t++) begin
      e_enc[t] = 1'b0; e_rdy[t] = 1'b0; e_lvl[t] = '0; e_grp[t] = '0; e_we[t] = '0;
      e_busy[t] = (t >= 1) && (t <= last_end + 1);
      e_done[t] = (t == last_end + 2);
      e_err[t]  = (t == 0) ? err_sticky : (wr_cyc >= 1 && t > wr_cyc);
    end
    if (wr_cyc == 0) e_we[1] = 4'(1 << ((int'(wa) / K) % EU));
    for (int i = 0; i < n; i++) begin
      lo = (i == 0) ? 1 : h[i-1] + ENC;
      for (int t = lo; t <= h[i]; t++) e_rdy[t] = 1'b1;
      for (int j = 0; j < ENC; j++) begin
        e_enc[h[i]+1+j] = 1'b1;
        e_lvl[h[i]+1+j] = 2'(j % TD);
        e_grp[h[i]+1+j] = 3'(j / TD);
      end
    end

    r = 0;
    vstart = (n > 0) ? gap_q[0] + 1 : 0;
    @(posedge clk); #1;
    for (int t = 0; t <= tend; t++) begin
      start = (t == 0) || (n > 0 && t == h[0] + 5);
      num_rows = (t == 0) ? 16'(n) : 16'($urandom_range(1, 9));
      bus_if.row_valid_i = (r < n) && (t >= vstart) && (t >= 1);
      bus_if.cfg_we_i    = (t == wr_cyc);
      bus_if.cfg_waddr_i = wa;
      bus_if.cfg_wdata_i = wd;
      @(negedge clk);
      checks++; if (encoder !== e_enc[t]) begin errors++; $display("FAIL %s t=%0d encoder_o got %b want %b", name, t, encoder, e_enc[t]); end
      checks++; if (busy !== e_busy[t]) begin errors++; $display("FAIL %s t=%0d busy_o got %b want %b", name, t, busy, e_busy[t]); end
      checks++; if (done !== e_done[t]) begin errors++; $display("FAIL %s t=%0d done_o got %b want %b", name, t, done, e_done[t]); end
      checks++; if (bus_if.row_ready_o !== e_rdy[t]) begin errors++; $display("FAIL %s t=%0d row_ready_o got %b want %b", name, t, bus_if.row_ready_o, e_rdy[t]); end
      checks++; if (enc_we !== e_we[t]) begin errors++; $display("FAIL %s t=%0d enc_we_o got %b want %b", name, t, enc_we, e_we[t]); end
      checks++; if (cfg_err !== e_err[t]) begin errors++; $display("FAIL %s t=%0d cfg_err_o got %b want %b", name, t, cfg_err, e_err[t]); end
      if (e_enc[t]) begin
        checks++; if (level !== e_lvl[t] || grp !== e_grp[t]) begin errors++; $display("FAIL %s t=%0d level/grp got %0d/%0d want %0d/%0d", name, t, level, grp, e_lvl[t], e_grp[t]); end
      end
      if (wr_cyc == 0 && t == 1) begin
        checks++; if (enc_waddr !== 7'(e_wa) || enc_wdata !== wd) begin errors++; $display("FAIL %s start_write addr/data got %0d/%h want %0d/%h", name, enc_waddr, enc_wdata, e_wa, wd); end
      end
`ifdef HALUT_ENC_SCHED_PERF_CNT_EN
      if (t == last_end + 2) begin
        checks++; if (stall_cnt !== 32'(exp_stall)) begin errors++; $display("FAIL %s stall_cnt_o got %0d want %0d", name, stall_cnt, exp_stall); end
      end
`endif
      if (bus_if.row_valid_i && bus_if.row_ready_o) begin
        r++;
        if (r < n) vstart = t + gap_q[r] + 1;
      end
      @(posedge clk); #1;
    end
    checks++; if (r != n) begin errors++; $display("FAIL %s handshakes got %0d want %0d", name, r, n); end
    start = 1'b0; bus_if.row_valid_i = 1'b0; bus_if.cfg_we_i = 1'b0;
    err_sticky = (wr_cyc >= 1);
  endtask

  task automatic test_single_row();
    gap_q[0] = 0;
    run_rows("single_row", 1, -1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) gap_q[i] = 0;
    run_rows("back_to_back", 3, -1);
  endtask

  task automatic test_stall();
    gap_q[0] = 0; gap_q[1] = ENC + 5;
    run_rows("stall", 2, -1);
  endtask

  task automatic test_zero_rows_busy_write();
    run_rows("zero_rows", 0, 1);
    gap_q[0] = 2;
    run_rows("err_clear_start_write", 1, 0);
  endtask

  task automatic test_random();
    int n;
    for (int it = 0; it < 5; it++) begin
      n = int'($urandom_range(1, 4));
      for (int i = 0; i < 8; i++) gap_q[i] = int'($urandom_range(0, 40));
      run_rows("random", n, (it % 2 == 0) ? -2 : -1);
    end
  endtask

  task automatic test_reset_midrun();
    @(posedge clk); #1;
    start = 1'b1; num_rows = 16'd1; bus_if.row_valid_i = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    checks++; if (encoder !== 1'b1 || level !== 2'd2 || grp !== 3'd2) begin errors++; $display("FAIL midrun_pre enc/level/grp got %b/%0d/%0d want 1/2/2", encoder, level, grp); end
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if ({encoder, busy, done, cfg_err, bus_if.row_ready_o} !== 5'b0) begin errors++; $display("FAIL midrun_reset ctrl {enc,busy,done,err,rdy} got %b want 00000", {encoder, busy, done, cfg_err, bus_if.row_ready_o}); end
    checks++; if (grp !== 3'd0 || level !== 2'd0 || enc_we !== 4'b0) begin errors++; $display("FAIL midrun_reset grp/level/we got %0d/%0d/%b want 0/0/0", grp, level, enc_we); end
    bus_if.row_valid_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    err_sticky = 1'b0;
    gap_q[0] = 0;
    run_rows("post_reset", 1, -1);
  endtask

  initial begin
    test_reset();
    test_cfg_routing();
    test_single_row();
    test_back_to_back();
    test_stall();
    test_zero_rows_busy_write();
    test_random();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
